// File: rtl/adder_share_sequencer_pkg.sv
// Shared types and constants for the adder share sequencer.
// Holds FSM state encodings, adder slice width and requester ids.
package adder_share_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int   SLICE_W = 3;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder_share_sequencer_ripplecarry.sv
// 3-bit ripple-carry adder slice shared by the sequencer.
// Ports: A, B operands; C_in carry in; Out sum; C_out carry out.
module adder_share_sequencer_ripplecarry
   import adder_share_sequencer_pkg::*;
(
   input  logic [SLICE_W-1:0] A,
   input  logic [SLICE_W-1:0] B,
   input  logic               C_in,
   output logic [SLICE_W-1:0] Out,
   output logic               C_out
);

   logic [SLICE_W:0] c;

   assign c[0] = C_in;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign Out[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
   end

   assign C_out = c[SLICE_W];

endmodule

// File: rtl/adder_share_sequencer.sv
// Shares one 3-bit adder slice between two requesters, sequencing
// WIDTH-bit add/sub over WIDTH/3 cycles with round-robin arbitration.
// Ports: clk/reset (sync, active-high); reqN_valid/ready/a/b/sub per
// requester; busy; res_valid pulse with res_data/carry/overflow/id.
module adder_share_sequencer
   import adder_share_sequencer_pkg::*;
#(
   parameter int WIDTH = 12
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             busy,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_carry,
   output logic             res_overflow,
   output logic             res_id
);

   localparam int SLICES = WIDTH / SLICE_W;
   localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int MSB    = WIDTH - 1;
   localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

   state_t           state_q, state_d;
   logic             rr_q, rr_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sub_q, sub_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_carry_q, res_carry_d;
   logic             res_ovf_q, res_ovf_d;
   logic             res_id_q, res_id_d;

   logic               grant0;
   logic               grant1;
   logic [SLICE_W-1:0] sl_a;
   logic [SLICE_W-1:0] sl_b;
   logic [SLICE_W-1:0] sl_sum;
   logic               sl_cout;
   logic [WIDTH-1:0]   acc_nxt;

   // rr_q = 0 favours req0 on contention, 1 favours req1
   assign grant0 = req0_valid & (~req1_valid | ~rr_q);
   assign grant1 = req1_valid & (~req0_valid |  rr_q);

   assign req0_ready = (state_q == IDLE) & grant0;
   assign req1_ready = (state_q == IDLE) & grant1;

   assign busy         = (state_q != IDLE);
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign res_carry    = res_carry_q;
   assign res_overflow = res_ovf_q;
   assign res_id       = res_id_q;

   assign sl_a = a_q[int'(k_q)*SLICE_W +: SLICE_W];
   assign sl_b = b_q[int'(k_q)*SLICE_W +: SLICE_W];

   // The only carry path between slices is through carry_q
   adder_share_sequencer_ripplecarry u_slice (
      .A     (sl_a),
      .B     (sl_b),
      .C_in  (carry_q),
      .Out   (sl_sum),
      .C_out (sl_cout)
   );

   always_comb begin
      acc_nxt = acc_q;
      acc_nxt[int'(k_q)*SLICE_W +: SLICE_W] = sl_sum;
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      k_d         = k_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sub_d       = sub_q;
      id_d        = id_q;
      acc_d       = acc_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_carry_d = res_carry_q;
      res_ovf_d   = res_ovf_q;
      res_id_d    = res_id_q;

      unique case (state_q)
         IDLE: begin
            if (grant0 | grant1) begin
               if (grant1) begin
                  id_d    = REQ1;
                  a_d     = req1_a;
                  b_d     = req1_b ^ {WIDTH{req1_sub}};
                  sub_d   = req1_sub;
                  carry_d = req1_sub;
                  rr_d    = 1'b0;
               end else begin
                  id_d    = REQ0;
                  a_d     = req0_a;
                  b_d     = req0_b ^ {WIDTH{req0_sub}};
                  sub_d   = req0_sub;
                  carry_d = req0_sub;
                  rr_d    = 1'b1;
               end
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = acc_nxt;
            carry_d = sl_cout;
            if (k_q == K_LAST) begin
               // Publish on entry to DONE so the pulse is registered
               state_d     = DONE;
               res_valid_d = 1'b1;
               res_data_d  = acc_nxt;
               res_carry_d = sl_cout;
               res_ovf_d   = (a_q[MSB] == b_q[MSB]) &&
                             (acc_nxt[MSB] != a_q[MSB]);
               res_id_d    = id_q;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_q        <= 1'b0;
         k_q         <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         id_q        <= REQ0;
         acc_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         res_ovf_q   <= 1'b0;
         res_id_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         k_q         <= k_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         id_q        <= id_d;
         acc_q       <= acc_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_carry_q <= res_carry_d;
         res_ovf_q   <= res_ovf_d;
         res_id_q    <= res_id_d;
      end
   end

   // sub_q is kept for observability of the in-flight op mode
   logic unused_sub;
   assign unused_sub = sub_q;

endmodule
